// File: rtl/booth_mul_param.sv
// -----------------------------------------------------------------------------
// booth_mul_param
//   Sequential radix-4 Booth multiplier. One Booth digit is retired per clock,
//   so a multiply takes WIDTH/2 cycles for signed operands and WIDTH/2+1 cycles
//   for unsigned operands. The extra unsigned step consumes the zero bits that
//   are added above the MSB by zero extension.
//
// Parameters
//   WIDTH        operand width in bits (even, 4..32)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   x            multiplicand
//   y            multiplier
//   signed_mode  1 = two's-complement operands, 0 = unsigned operands
//   start        request a multiply (accepted in IDLE or DONE)
//   z            registered product, 2*WIDTH bits
//   busy         high while Booth iterations are in progress
//   done         one-cycle pulse when z has been updated
// -----------------------------------------------------------------------------
module booth_mul_param #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               signed_mode,
  input  logic               start,
  output logic [2*WIDTH-1:0] z,
  output logic               busy,
  output logic               done
);

  // Operand width after sign/zero extension.
  localparam int EW = WIDTH + 2;
  // Upper (partial-product) field. Its running value stays below 3*2^WIDTH in
  // magnitude, so two bits of headroom over EW are enough for the +/-2 multiples
  // of the most-negative operand.
  localparam int HW = WIDTH + 4;
  // Lower field: extended multiplier plus the implicit zero below its LSB.
  localparam int LW = EW + 1;
  localparam int AW = HW + LW;

  // Counter value on the final Booth step for each mode.
  localparam logic [5:0] LAST_SIGNED   = 6'(WIDTH / 2 - 1);
  localparam logic [5:0] LAST_UNSIGNED = 6'(WIDTH / 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   m_q;        // captured, extended multiplicand
  logic            mode_q;     // captured signed_mode
  logic [AW-1:0]   acc_q;      // {partial product, remaining multiplier}
  logic [5:0]      cnt_q;      // Booth step counter

  logic [EW-1:0]   x_ext;
  logic [EW-1:0]   y_ext;
  logic [HW-1:0]   m_wide;
  logic [HW-1:0]   addend;
  logic [HW-1:0]   hi_sum;
  logic signed [AW-1:0] acc_pre;
  logic [AW-1:0]   acc_step;
  logic [2*WIDTH-1:0] product;
  logic            last_step;

  // Extension: replicate the MSB only in signed mode.
  assign x_ext = {{2{signed_mode & x[WIDTH-1]}}, x};
  assign y_ext = {{2{signed_mode & y[WIDTH-1]}}, y};

  assign m_wide = {{(HW-EW){m_q[EW-1]}}, m_q};

  // Radix-4 Booth digit from the three lowest bits of the multiplier field.
  always_comb begin
    // NOTE: default first so every path assigns addend and no latch is inferred.
    addend = '0;
    unique case (acc_q[2:0])
      3'b001, 3'b010: addend = m_wide;
      3'b011:         addend = m_wide << 1;
      3'b100:         addend = -(m_wide << 1);
      3'b101, 3'b110: addend = -m_wide;
      default:        addend = '0;
    endcase
  end

  assign hi_sum   = acc_q[AW-1 -: HW] + addend;
  assign acc_pre  = {hi_sum, acc_q[LW-1:0]};
  assign acc_step = AW'(acc_pre >>> 2);

  // After ITER shifts the product's LSB sits at bit LW - 2*ITER of the
  // accumulator: bit 3 for signed (ITER = WIDTH/2), bit 1 for unsigned.
  assign product   = mode_q ? acc_step[3 +: 2*WIDTH] : acc_step[1 +: 2*WIDTH];
  assign last_step = (cnt_q == (mode_q ? LAST_SIGNED : LAST_UNSIGNED));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    state_d = start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= '0;
      mode_q <= 1'b0;
      acc_q  <= '0;
      cnt_q  <= '0;
      z      <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            m_q    <= x_ext;
            mode_q <= signed_mode;
            acc_q  <= {{HW{1'b0}}, y_ext, 1'b0};
            cnt_q  <= '0;
          end
        end
        CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 6'd1;
          if (last_step) z <= product;
        end
        default: ;
      endcase
    end
  end

  // Both flags decode the state register directly, so they are glitch-free.
  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_booth_mul_param.sv
// -----------------------------------------------------------------------------
// tb_booth_mul_param
//   Self-checking bench for booth_mul_param. A WIDTH=16 instance runs a table
//   of directed vectors plus mid-CALC start and mid-CALC reset sequences; a
//   WIDTH=8 instance runs back-to-back random operations against a reference
//   product computed here.
// -----------------------------------------------------------------------------
module tb_booth_mul_param;

  logic clk;
  logic rst_n;

  // WIDTH = 16 instance
  logic [15:0] x16, y16;
  logic        sm16, start16;
  logic [31:0] z16;
  logic        busy16, done16;

  // WIDTH = 8 instance
  logic [7:0]  x8, y8;
  logic        sm8, start8;
  logic [15:0] z8;
  logic        busy8, done8;

  int n_checks;
  int n_pass;

  booth_mul_param #(.WIDTH(16)) dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x16),
    .y          (y16),
    .signed_mode(sm16),
    .start      (start16),
    .z          (z16),
    .busy       (busy16),
    .done       (done16)
  );

  booth_mul_param #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x8),
    .y          (y8),
    .signed_mode(sm8),
    .start      (start8),
    .z          (z8),
    .busy       (busy8),
    .done       (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        sm;
    logic [31:0] z;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One WIDTH=16 operation: start pulse, count busy cycles, check result,
  // done pulse width and return to IDLE.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                       input logic [31:0] exp, input string name);
    int cyc;
    @(negedge clk);
    x16 = a; y16 = b; sm16 = sm; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 0;
    while (busy16 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    check({name, " latency"}, 64'(cyc), sm ? 64'd8 : 64'd9);
    check({name, " done"}, 64'(done16), 64'd1);
    check({name, " z"}, 64'(z16), 64'(exp));
    @(negedge clk);
    check({name, " done width"}, 64'(done16), 64'd0);
    check({name, " z hold"}, 64'(z16), 64'(exp));
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int ia, ib, p;
    ia = sm ? int'($signed(a)) : int'(a);
    ib = sm ? int'($signed(b)) : int'(b);
    p  = ia * ib;
    return p[15:0];
  endfunction

  vec_t vecs[12];

  initial begin
    int done_cnt;
    int cyc;
    int idx;
    int guard;
    logic [7:0] ax[10];
    logic [7:0] ay[10];
    logic       asm[10];

    n_checks = 0;
    n_pass   = 0;

    vecs[0]  = '{16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1};
    vecs[1]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
    vecs[2]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001};
    vecs[3]  = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
    vecs[4]  = '{16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000};
    vecs[5]  = '{16'h1234, 16'h5678, 1'b0, 32'h0626_0060};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 32'h4000_0000};
    vecs[7]  = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001};
    vecs[8]  = '{16'h0000, 16'hFFFF, 1'b1, 32'h0000_0000};
    vecs[9]  = '{16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF};
    vecs[10] = '{16'hFFFF, 16'h0001, 1'b0, 32'h0000_FFFF};
    vecs[11] = '{16'h0007, 16'h0006, 1'b0, 32'h0000_002A};

    x16 = '0; y16 = '0; sm16 = 1'b0; start16 = 1'b0;
    x8  = '0; y8  = '0; sm8  = 1'b0; start8  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset z", 64'(z16), 64'd0);
    check("reset busy", 64'(busy16), 64'd0);
    check("reset done", 64'(done16), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++)
      run16(vecs[i].x, vecs[i].y, vecs[i].sm, vecs[i].z, $sformatf("vec%0d", i));

    // Start and operand changes during CALC must be ignored.
    @(negedge clk);
    x16 = 16'h0003; y16 = 16'h0004; sm16 = 1'b1; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (2) @(negedge clk);
    x16 = 16'h0100; y16 = 16'h0100; sm16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (done16) begin
        done_cnt++;
        check("midstart z", 64'(z16), 64'd12);
      end
      @(negedge clk);
    end
    check("midstart done count", 64'(done_cnt), 64'd1);

    // Reset during CALC aborts the operation.
    @(negedge clk);
    x16 = 16'h1234; y16 = 16'h5678; sm16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort z", 64'(z16), 64'd0);
    check("abort busy", 64'(busy16), 64'd0);
    check("abort done", 64'(done16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done16 || busy16) done_cnt++;
    end
    check("abort no done", 64'(done_cnt), 64'd0);
    run16(16'h0007, 16'h0006, 1'b0, 32'd42, "after reset");

    // WIDTH=8 back-to-back, start held high across DONE.
    ax[0] = 8'h80; ay[0] = 8'h80; asm[0] = 1'b1;
    ax[1] = 8'hFF; ay[1] = 8'hFF; asm[1] = 1'b0;
    for (int i = 2; i < 10; i++) begin
      ax[i]  = 8'($urandom_range(0, 255));
      ay[i]  = 8'($urandom_range(0, 255));
      asm[i] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    x8 = ax[0]; y8 = ay[0]; sm8 = asm[0]; start8 = 1'b1;
    idx = 0; cyc = 0; guard = 0;
    while (idx < 10 && guard < 200) begin
      @(negedge clk);
      cyc++;
      guard++;
      if (done8) begin
        check($sformatf("w8 op%0d z", idx), 64'(z8), 64'(ref8(ax[idx], ay[idx], asm[idx])));
        check($sformatf("w8 op%0d latency", idx), 64'(cyc - 1), asm[idx] ? 64'd4 : 64'd5);
        idx++;
        cyc = 0;
        if (idx < 10) begin
          x8 = ax[idx]; y8 = ay[idx]; sm8 = asm[idx];
        end else begin
          start8 = 1'b0;
        end
      end
    end
    check("w8 all ops completed", 64'(idx), 64'd10);
    @(negedge clk);
    check("w8 back to idle", 64'({busy8, done8}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
